// File: rtl/gpu_ucode_sequencer.sv
// -----------------------------------------------------------------------------
// gpu_ucode_sequencer
//
// Microcode sequencer for the GPU scanline engine. It owns the micro-program
// counter, addresses the combinational microcode ROM, issues datapath uops,
// resolves goto/jz/jnz internally and stalls on the VRAM-read and BG-write
// handshakes. A watchdog flags a datapath that never acknowledges.
//
// Ports:
//   Clock      in   1  system clock, rising edge
//   Reset      in   1  asynchronous, active-high
//   iEnable    in   1  run request (LCD on)
//   iRestart   in   1  pulse: restart program at address 0 at the next fetch
//   oUopAddr   out  8  ROM address (= PC)
//   iUop       in  20  ROM data, combinational from oUopAddr
//   oUop       out 20  last issued uop
//   oUopValid  out  1  one-cycle strobe: datapath executes oUop
//   iZero      in   1  datapath zero flag, sampled while a jump executes
//   oVmemReq   out  1  VRAM read request (level)
//   iVmemAck   in   1  VRAM read data valid
//   oBgWrReq   out  1  BG buffer write request (level)
//   iBgWrAck   in   1  BG buffer write accepted
//   oRunning   out  1  high whenever the sequencer is not idle
//   oError     out  1  sticky ack-timeout flag, cleared only by Reset
//
// All outputs come straight from registers. Issue-related outputs (oUop,
// oUopValid and the request levels) are loaded at the fetch edge from the
// ROM word, so they are visible during the execute cycle of that uop.
// -----------------------------------------------------------------------------
module gpu_ucode_sequencer #(
  parameter logic [4:0] OP_NOP      = 5'd0,
  parameter logic [4:0] OP_GOTO     = 5'd1,
  parameter logic [4:0] OP_JZ       = 5'd2,
  parameter logic [4:0] OP_JNZ      = 5'd3,
  parameter logic [4:0] OP_RVMEM    = 5'd4,
  parameter logic [4:0] OP_WBG      = 5'd5,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  input  logic        iRestart,
  output logic [7:0]  oUopAddr,
  input  logic [19:0] iUop,
  output logic [19:0] oUop,
  output logic        oUopValid,
  input  logic        iZero,
  output logic        oVmemReq,
  input  logic        iVmemAck,
  output logic        oBgWrReq,
  input  logic        iBgWrAck,
  output logic        oRunning,
  output logic        oError
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_WAIT_VMEM = 3'd3,
    ST_WAIT_BG   = 3'd4
  } state_t;

  // Control-flow uops never reach the datapath.
  function automatic logic is_flow_op(input logic [4:0] op);
    logic flow;
    if ((op == OP_NOP) || (op == OP_GOTO) || (op == OP_JZ) || (op == OP_JNZ)) begin
      flow = 1'b1;
    end else begin
      flow = 1'b0;
    end
    return flow;
  endfunction

  // Successor PC of a control-flow uop; anything that is not a jump falls through.
  function automatic logic [7:0] flow_pc(input logic [4:0] op,
                                         input logic [7:0] tgt,
                                         input logic [7:0] inc,
                                         input logic       zero);
    logic [7:0] npc;
    if (op == OP_GOTO) begin
      npc = tgt;
    end else if (op == OP_JZ) begin
      npc = zero ? tgt : inc;
    end else if (op == OP_JNZ) begin
      npc = zero ? inc : tgt;
    end else begin
      npc = inc;
    end
    return npc;
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    pc_r, pc_s;
  // Only the fields EXEC decodes are held; the full word already sits in oUop.
  logic [4:0]    ir_op_r, ir_op_s;
  logic [7:0]    ir_tgt_r, ir_tgt_s;
  logic [19:0]   uop_r, uop_s;
  logic          uop_valid_r, uop_valid_s;
  logic          vmem_req_r, vmem_req_s;
  logic          bg_req_r, bg_req_s;
  logic          running_r, running_s;
  logic          error_r, error_s;
  logic          pend_r, pend_s;
  logic [CW-1:0] cnt_r, cnt_s;

  logic [4:0]    fetch_op_s;
  logic [7:0]    pc_inc_s;
  logic          ack_s;

  assign fetch_op_s = iUop[19:15];
  assign pc_inc_s   = pc_r + 8'd1;
  assign ack_s      = (state_r == ST_WAIT_VMEM) ? iVmemAck : iBgWrAck;

  assign oUopAddr  = pc_r;
  assign oUop      = uop_r;
  assign oUopValid = uop_valid_r;
  assign oVmemReq  = vmem_req_r;
  assign oBgWrReq  = bg_req_r;
  assign oRunning  = running_r;
  assign oError    = error_r;

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ir_op_s     = ir_op_r;
    ir_tgt_s    = ir_tgt_r;
    uop_s       = uop_r;
    uop_valid_s = 1'b0;
    vmem_req_s  = vmem_req_r;
    bg_req_s    = bg_req_r;
    error_s     = error_r;
    cnt_s       = cnt_r;
    // Restart pulses collapse into one pending request.
    pend_s      = pend_r | iRestart;

    case (state_r)
      ST_IDLE: begin
        // Leaving IDLE always starts at 0, so a pending restart is moot.
        pend_s     = 1'b0;
        vmem_req_s = 1'b0;
        bg_req_s   = 1'b0;
        if (iEnable && !error_r) begin
          state_s = ST_FETCH;
          pc_s    = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (!iEnable) begin
          state_s = ST_IDLE;
        end else if (pend_r) begin
          // Spend this cycle rewinding; the real fetch at 0 follows.
          pc_s    = 8'd0;
          pend_s  = iRestart;
          state_s = ST_FETCH;
        end else begin
          ir_op_s  = fetch_op_s;
          ir_tgt_s = iUop[7:0];
          cnt_s    = '0;
          state_s  = ST_EXEC;
          if (is_flow_op(fetch_op_s)) begin
            uop_valid_s = 1'b0;
          end else begin
            uop_s       = iUop;
            uop_valid_s = 1'b1;
          end
          if (fetch_op_s == OP_RVMEM) begin
            vmem_req_s = 1'b1;
          end else if (fetch_op_s == OP_WBG) begin
            bg_req_s = 1'b1;
          end else begin
            vmem_req_s = 1'b0;
            bg_req_s   = 1'b0;
          end
        end
      end

      ST_EXEC: begin
        // Acks seen here are ignored; only the wait states look at them.
        cnt_s = '0;
        if (ir_op_r == OP_RVMEM) begin
          state_s = ST_WAIT_VMEM;
        end else if (ir_op_r == OP_WBG) begin
          state_s = ST_WAIT_BG;
        end else begin
          pc_s    = flow_pc(ir_op_r, ir_tgt_r, pc_inc_s, iZero);
          state_s = iEnable ? ST_FETCH : ST_IDLE;
        end
      end

      ST_WAIT_VMEM, ST_WAIT_BG: begin
        if (ack_s) begin
          vmem_req_s = 1'b0;
          bg_req_s   = 1'b0;
          pc_s       = pc_inc_s;
          state_s    = iEnable ? ST_FETCH : ST_IDLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          error_s    = 1'b1;
          vmem_req_s = 1'b0;
          bg_req_s   = 1'b0;
          cnt_s      = cnt_r + CNT_ONE;
          state_s    = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        vmem_req_s = 1'b0;
        bg_req_s   = 1'b0;
      end
    endcase

    running_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= 8'd0;
      ir_op_r     <= 5'd0;
      ir_tgt_r    <= 8'd0;
      uop_r       <= 20'd0;
      uop_valid_r <= 1'b0;
      vmem_req_r  <= 1'b0;
      bg_req_r    <= 1'b0;
      running_r   <= 1'b0;
      error_r     <= 1'b0;
      pend_r      <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_op_r     <= ir_op_s;
      ir_tgt_r    <= ir_tgt_s;
      uop_r       <= uop_s;
      uop_valid_r <= uop_valid_s;
      vmem_req_r  <= vmem_req_s;
      bg_req_r    <= bg_req_s;
      running_r   <= running_s;
      error_r     <= error_s;
      pend_r      <= pend_s;
      cnt_r       <= cnt_s;
    end
  end

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for gpu_ucode_sequencer: directed scenarios plus a
// randomized program checked against an instruction-level timing model.
// Cycle numbering: cycle 0 is the first fetch after leaving reset; outputs are
// sampled and inputs driven on the falling edge of each cycle.
// -----------------------------------------------------------------------------
module tb_gpu_ucode_sequencer;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_GOTO  = 5'd1;
  localparam logic [4:0] OP_JZ    = 5'd2;
  localparam logic [4:0] OP_JNZ   = 5'd3;
  localparam logic [4:0] OP_RVMEM = 5'd4;
  localparam logic [4:0] OP_WBG   = 5'd5;
  localparam int         TMO      = 16;
  localparam int         NCYC     = 500;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iEnable = 1'b0, iRestart = 1'b0, iZero = 1'b0;
  logic        iVmemAck = 1'b0, iBgWrAck = 1'b0;
  logic [7:0]  oUopAddr;
  logic [19:0] iUop, oUop;
  logic        oUopValid, oVmemReq, oBgWrReq, oRunning, oError;

  logic [19:0] rom [256];
  assign iUop = rom[oUopAddr];

  int n_checks = 0;
  int n_pass   = 0;

  gpu_ucode_sequencer #(
    .OP_NOP(OP_NOP), .OP_GOTO(OP_GOTO), .OP_JZ(OP_JZ), .OP_JNZ(OP_JNZ),
    .OP_RVMEM(OP_RVMEM), .OP_WBG(OP_WBG), .ACK_TIMEOUT(TMO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iRestart(iRestart),
    .oUopAddr(oUopAddr), .iUop(iUop), .oUop(oUop), .oUopValid(oUopValid),
    .iZero(iZero), .oVmemReq(oVmemReq), .iVmemAck(iVmemAck),
    .oBgWrReq(oBgWrReq), .iBgWrAck(iBgWrAck), .oRunning(oRunning), .oError(oError)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [19:0] jmp(input logic [4:0] op, input logic [7:0] tgt);
    return {op, 7'd0, tgt};
  endfunction

  task automatic fill_rom_nop();
    for (int i = 0; i < 256; i++) rom[i] = 20'd0;
  endtask

  // Reset, then release with iEnable high; the next falling edge is cycle 0.
  task automatic start_run();
    Reset = 1'b1; iEnable = 1'b0; iRestart = 1'b0;
    iVmemAck = 1'b0; iBgWrAck = 1'b0;
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0; iEnable = 1'b1;
  endtask

  task automatic test_reset();
    fill_rom_nop();
    Reset = 1'b1; iEnable = 1'b1;
    @(negedge Clock); @(negedge Clock);
    n_checks++;
    if ({oUopAddr, oUop} !== 28'd0) $display("FAIL reset_addr_uop: got %h/%h expected 0/0", oUopAddr, oUop);
    else n_pass++;
    n_checks++;
    if ({oUopValid, oVmemReq, oBgWrReq, oRunning, oError} !== 5'b00000)
      $display("FAIL reset_flags: got %b expected 00000", {oUopValid, oVmemReq, oBgWrReq, oRunning, oError});
    else n_pass++;
  endtask

  task automatic test_loop();
    logic [19:0] alu;
    alu = {5'd9, 15'h1234};
    fill_rom_nop();
    rom[1] = alu; rom[2] = jmp(OP_GOTO, 8'd0);
    start_run();
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      n_checks++;
      if (oUopAddr !== 8'((c % 6) / 2)) $display("FAIL loop_addr c%0d: got %0d expected %0d", c, oUopAddr, (c % 6) / 2);
      else n_pass++;
      n_checks++;
      if (oUopValid !== ((c % 6) == 3)) $display("FAIL loop_valid c%0d: got %b expected %b", c, oUopValid, (c % 6) == 3);
      else n_pass++;
      if ((c % 6) == 3) begin
        n_checks++;
        if (oUop !== alu) $display("FAIL loop_uop c%0d: got %h expected %h", c, oUop, alu);
        else n_pass++;
      end
    end
  endtask

  task automatic test_jumps();
    logic [4:0] op;
    logic       z, taken;
    for (int k = 0; k < 4; k++) begin
      op = (k < 2) ? OP_JNZ : OP_JZ;
      z  = k[0];
      taken = (op == OP_JZ) ? z : !z;
      fill_rom_nop();
      rom[0] = jmp(OP_GOTO, 8'd5);
      rom[5] = {op, 7'h55, 8'd3};
      rom[3] = jmp(OP_GOTO, 8'd3);
      rom[6] = jmp(OP_GOTO, 8'd6);
      iZero = z;
      start_run();
      for (int c = 0; c < 5; c++) begin
        @(negedge Clock);
        if (c == 2) begin
          n_checks++;
          if (oUopAddr !== 8'd5) $display("FAIL jump_pre k%0d: got %0d expected 5", k, oUopAddr);
          else n_pass++;
        end
        if (c == 4) begin
          n_checks++;
          if (oUopAddr !== (taken ? 8'd3 : 8'd6))
            $display("FAIL jump_dest k%0d: got %0d expected %0d", k, oUopAddr, taken ? 3 : 6);
          else n_pass++;
        end
        if (c == 3) begin
          n_checks++;
          if (oUopValid !== 1'b0) $display("FAIL jump_novalid k%0d: got %b expected 0", k, oUopValid);
          else n_pass++;
        end
      end
    end
    iZero = 1'b0;
  endtask

  task automatic test_rvmem();
    int nreq, nval;
    fill_rom_nop();
    rom[0] = jmp(OP_GOTO, 8'd6);
    rom[6] = {OP_RVMEM, 15'h0abc};
    rom[7] = jmp(OP_GOTO, 8'd7);
    start_run();
    nreq = 0; nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      nreq += int'(oVmemReq);
      nval += int'(oUopValid);
      if (c == 3) begin
        n_checks++;
        if (oUop !== rom[6]) $display("FAIL rvmem_uop: got %h expected %h", oUop, rom[6]);
        else n_pass++;
      end
      if (c == 7) begin
        n_checks++;
        if (oUopAddr !== 8'd7) $display("FAIL rvmem_next: got %0d expected 7", oUopAddr);
        else n_pass++;
      end
      // Ack during EXEC (cycle 3) must be ignored; ack in the third wait counts.
      iVmemAck = (c == 3) || (c == 6);
    end
    iVmemAck = 1'b0;
    n_checks++;
    if (nreq != 4) $display("FAIL rvmem_req_len: got %0d expected 4", nreq);
    else n_pass++;
    n_checks++;
    if (nval != 1) $display("FAIL rvmem_valid_cnt: got %0d expected 1", nval);
    else n_pass++;
    // Reset mid-wait drops the request without waiting for a clock edge.
    start_run();
    for (int c = 0; c < 6; c++) @(negedge Clock);
    n_checks++;
    if (oVmemReq !== 1'b1) $display("FAIL rvmem_waiting: got %b expected 1", oVmemReq);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({oVmemReq, oRunning, oUopAddr} !== 10'd0)
      $display("FAIL async_reset: got req=%b run=%b addr=%0d expected 0/0/0", oVmemReq, oRunning, oUopAddr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int nreq;
    fill_rom_nop();
    rom[0] = {OP_WBG, 15'h0155};
    start_run();
    nreq = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      nreq += int'(oBgWrReq);
      if (c == 17) begin
        n_checks++;
        if ({oBgWrReq, oError, oRunning} !== 3'b101)
          $display("FAIL tmo_last_wait: got req/err/run=%b expected 101", {oBgWrReq, oError, oRunning});
        else n_pass++;
      end
      if (c == 18) begin
        n_checks++;
        if ({oBgWrReq, oError, oRunning} !== 3'b010)
          $display("FAIL tmo_fire: got req/err/run=%b expected 010", {oBgWrReq, oError, oRunning});
        else n_pass++;
      end
      iRestart = (c == 20);
    end
    n_checks++;
    if (nreq != TMO + 1) $display("FAIL tmo_req_len: got %0d expected %0d", nreq, TMO + 1);
    else n_pass++;
    n_checks++;
    if ({oError, oRunning} !== 2'b10) $display("FAIL tmo_sticky: got err/run=%b expected 10", {oError, oRunning});
    else n_pass++;
    Reset = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (oError !== 1'b0) $display("FAIL tmo_reset_clear: got %b expected 0", oError);
    else n_pass++;
    Reset = 1'b0;
    @(negedge Clock);
    n_checks++;
    if (oRunning !== 1'b1) $display("FAIL tmo_restart_run: got %b expected 1", oRunning);
    else n_pass++;
  endtask

  task automatic test_restart();
    fill_rom_nop();
    rom[0]  = jmp(OP_GOTO, 8'd12);
    rom[12] = {OP_RVMEM, 15'h0111};
    rom[13] = {5'd20, 15'h0013};
    start_run();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (c == 7 || c == 8) begin
        n_checks++;
        if (oUopAddr !== 8'd0) $display("FAIL restart_addr c%0d: got %0d expected 0", c, oUopAddr);
        else n_pass++;
      end
      if (c == 9) begin
        n_checks++;
        if (oUopAddr !== 8'd12) $display("FAIL restart_loop: got %0d expected 12", oUopAddr);
        else n_pass++;
      end
      if (c >= 6) begin
        n_checks++;
        if (oUopValid !== 1'b0) $display("FAIL restart_noissue c%0d: got %b expected 0", c, oUopValid);
        else n_pass++;
      end
      iRestart = (c == 4);
      iVmemAck = (c == 5);
    end
    iRestart = 1'b0; iVmemAck = 1'b0;
  endtask

  task automatic test_wrap_enable();
    fill_rom_nop();
    rom[0] = jmp(OP_GOTO, 8'd255);
    start_run();
    for (int c = 0; c < 11; c++) begin
      @(negedge Clock);
      if (c == 2 || c == 4 || c == 10) begin
        n_checks++;
        if (oUopAddr !== ((c == 2) ? 8'd255 : 8'd0))
          $display("FAIL wrap_addr c%0d: got %0d expected %0d", c, oUopAddr, (c == 2) ? 255 : 0);
        else n_pass++;
      end
      if (c >= 5) begin
        n_checks++;
        if (oRunning !== (c == 5 || c == 10)) $display("FAIL enable_run c%0d: got %b expected %b", c, oRunning, c == 5 || c == 10);
        else n_pass++;
      end
      if (c == 5) iEnable = 1'b0;
      if (c == 9) iEnable = 1'b1;
    end
  endtask

  // Random program vs. instruction-level model: each uop costs fetch+exec,
  // memory uops add their wait cycles, a pending restart costs one rewind cycle.
  logic        zero_at [NCYC];
  logic        rs_at   [NCYC];
  int          delays  [300];
  logic [7:0]  e_addr  [NCYC];
  logic        e_valid [NCYC];
  logic [19:0] e_uop   [NCYC];
  logic        e_vreq  [NCYC];
  logic        e_breq  [NCYC];

  task automatic put(input int x, input logic [7:0] a, input logic v, input logic [19:0] u,
                     input logic vr, input logic br);
    if (x < NCYC) begin
      e_addr[x] = a; e_valid[x] = v; e_uop[x] = u; e_vreq[x] = vr; e_breq[x] = br;
    end
  endtask

  task automatic test_random();
    int t, scan, di, ri, hic, cur_d, sel, d;
    logic [7:0]  pc;
    logic        pend, ack;
    logic [19:0] u, last;
    logic [4:0]  op;
    for (int i = 0; i < 256; i++) begin
      sel = $urandom_range(0, 9);
      u = 20'($urandom);
      case (sel)
        0: u[19:15] = OP_NOP;
        1: u[19:15] = OP_GOTO;
        2: u[19:15] = OP_JZ;
        3: u[19:15] = OP_JNZ;
        4: u[19:15] = OP_RVMEM;
        5: u[19:15] = OP_WBG;
        default: u[19:15] = 5'($urandom_range(6, 31));
      endcase
      rom[i] = u;
    end
    for (int c = 0; c < NCYC; c++) begin
      zero_at[c] = 1'($urandom);
      rs_at[c]   = ($urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 300; i++) delays[i] = $urandom_range(1, 5);

    t = 0; scan = 0; di = 0; pc = 8'd0; pend = 1'b0; last = 20'd0;
    while (t < NCYC) begin
      for (int c = scan; c < t; c++) if (rs_at[c]) pend = 1'b1;
      scan = t;
      put(t, pc, 1'b0, last, 1'b0, 1'b0);
      if (pend) begin
        pend = 1'b0; pc = 8'd0; t = t + 1;
      end else begin
        u = rom[pc]; op = u[19:15];
        if (op == OP_RVMEM || op == OP_WBG) begin
          last = u;
          d = delays[di]; di++;
          for (int k = 0; k <= d; k++)
            put(t + 1 + k, pc, k == 0, last, op == OP_RVMEM, op == OP_WBG);
          pc = pc + 8'd1; t = t + 2 + d;
        end else if (op == OP_NOP || op == OP_GOTO || op == OP_JZ || op == OP_JNZ) begin
          put(t + 1, pc, 1'b0, last, 1'b0, 1'b0);
          if (op == OP_GOTO || (op == OP_JZ && zero_at[t + 1 < NCYC ? t + 1 : 0]) ||
              (op == OP_JNZ && !zero_at[t + 1 < NCYC ? t + 1 : 0]))
            pc = u[7:0];
          else
            pc = pc + 8'd1;
          t = t + 2;
        end else begin
          last = u;
          put(t + 1, pc, 1'b1, last, 1'b0, 1'b0);
          pc = pc + 8'd1; t = t + 2;
        end
      end
    end

    start_run();
    ri = 0; hic = 0; cur_d = 1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge Clock);
      n_checks++;
      if ({oUopAddr, oUopValid, oUop, oVmemReq, oBgWrReq} !== {e_addr[c], e_valid[c], e_uop[c], e_vreq[c], e_breq[c]})
        $display("FAIL rand c%0d: got addr=%0d v=%b uop=%h vr=%b br=%b expected addr=%0d v=%b uop=%h vr=%b br=%b",
                 c, oUopAddr, oUopValid, oUop, oVmemReq, oBgWrReq,
                 e_addr[c], e_valid[c], e_uop[c], e_vreq[c], e_breq[c]);
      else n_pass++;
      n_checks++;
      if ({oRunning, oError} !== 2'b10) $display("FAIL rand_status c%0d: got run/err=%b expected 10", c, {oRunning, oError});
      else n_pass++;
      iZero    = zero_at[c];
      iRestart = rs_at[c];
      if (oVmemReq || oBgWrReq) begin
        hic++;
        if (hic == 1) begin
          cur_d = (ri < 300) ? delays[ri] : 1;
          ri++;
        end
      end else begin
        hic = 0;
      end
      ack = (hic == cur_d + 1);
      iVmemAck = ack & oVmemReq;
      iBgWrAck = ack & oBgWrReq;
    end
    iRestart = 1'b0; iVmemAck = 1'b0; iBgWrAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loop();
    test_jumps();
    test_rvmem();
    test_timeout();
    test_restart();
    test_wrap_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_ucode_sequencer.md
Name: gpu_ucode_sequencer

Overview:
- Microcode sequencer for the GPU scanline engine.
- Owns the micro-program counter and drives the address of the combinational GPU microcode ROM.
- Issues each fetched 20-bit uop to the GPU datapath and resolves control-flow uops (goto, jz, jnz) internally.
- Stalls on VRAM read and BG-buffer write handshakes, with a watchdog that flags a datapath that never acknowledges.

Parameters:
- OP_NOP, 5'd0: opcode of nop; must equal the team GPU opcode definitions.
- OP_GOTO, 5'd1: opcode of unconditional jump.
- OP_JZ, 5'd2: opcode of jump-if-zero.
- OP_JNZ, 5'd3: opcode of jump-if-not-zero.
- OP_RVMEM, 5'd4: opcode of VRAM read.
- OP_WBG, 5'd5: opcode of BG buffer write.
- ACK_TIMEOUT, 16: maximum wait cycles for an ack before error.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- iEnable  in  1  run request (LCD on).
- iRestart  in  1  one-cycle pulse: restart program at address 0 (frame start).
- oUopAddr  out  8  ROM address (= PC).
- iUop  in  20  ROM data; combinational from oUopAddr.
- oUop  out  20  issued uop to datapath.
- oUopValid  out  1  one-cycle strobe: datapath executes oUop.
- iZero  in  1  datapath zero flag from most recently executed arithmetic uop.
- oVmemReq  out  1  VRAM read request (level).
- iVmemAck  in  1  VRAM read data valid.
- oBgWrReq  out  1  BG buffer write request (level).
- iBgWrAck  in  1  BG buffer write accepted.
- oRunning  out  1  high in any state except IDLE.
- oError  out  1  sticky ack-timeout flag; cleared only by Reset.

Behaviour:
- Uop fields:
  - op = Uop[19:15].
  - Jump target = Uop[7:0]; Uop[14:8] are ignored for jumps.
- Reset values:
  - PC = 0, state IDLE, instruction register (IR) = 0.
  - oUop = 0; oUopValid, oVmemReq, oBgWrReq, oRunning, oError = 0.
  - Restart-pending flag = 0, timeout counter = 0.
- States: IDLE, FETCH, EXEC, WAIT_VMEM, WAIT_BG.
- IDLE:
  - If iEnable=1 and oError=0 -> FETCH, with PC = 0.
  - Otherwise stay in IDLE.
- FETCH (one cycle):
  - oUopAddr = PC; IR <= iUop; -> EXEC.
  - If iEnable=0 at this boundary: -> IDLE, no fetch.
  - If restart is pending: PC <= 0, clear pending, fetch at address 0 on the following FETCH cycle.
- EXEC (one cycle), by op:
  - GOTO: PC <= target.
  - JZ: PC <= iZero ? target : PC+1.
  - JNZ: PC <= iZero ? PC+1 : target.
  - NOP: PC <= PC+1.
  - For all four above, oUopValid stays 0 and next state is FETCH.
  - RVMEM: oUop <= IR, oUopValid=1 for this cycle only, oVmemReq=1, counter cleared -> WAIT_VMEM.
  - WBG: same as RVMEM but with oBgWrReq -> WAIT_BG.
  - Any other op: oUop <= IR, oUopValid=1, PC <= PC+1 -> FETCH.
- Latency:
  - Plain datapath uop: 2 cycles (fetch + exec).
  - Taken or untaken jump: 2 cycles.
  - iZero is sampled in EXEC. It reflects the uop issued at least 2 cycles earlier, so no hazard exists.
- WAIT_VMEM / WAIT_BG:
  - Request held high.
  - Ack sampled high -> drop request, PC <= PC+1 -> FETCH.
  - An ack present in the EXEC cycle is ignored; only acks in a WAIT state count.
  - Counter increments each wait cycle. On reaching ACK_TIMEOUT without ack: set oError, drop request -> IDLE.
- PC arithmetic is 8-bit; PC+1 from 255 wraps to 0.
- iRestart:
  - Latched into the pending flag in any state; multiple pulses collapse to one.
  - Never aborts EXEC or WAIT states; takes effect at the next FETCH.
  - In IDLE, the pending flag is cleared, since entry from IDLE always starts at 0.
- iEnable deasserted mid-operation: the current EXEC/WAIT completes normally, then IDLE at the next FETCH boundary.
- oRunning is registered: it equals (next state != IDLE).
- Reset asserted mid-wait: immediate return to reset values; requests drop asynchronously.

Test Plan:
- Reset, iEnable=1, ROM = {0:NOP, 1:ALU, 2:GOTO 0} -> oUopAddr sequence 0,1,2,0; oUopValid pulses only for address 1, once per 6-cycle loop.
- ROM {5:JNZ 3}, iZero=0 then iZero=1 -> first PC goes 5->3; second PC goes 5->6.
- RVMEM at addr 6, iVmemAck after 3 wait cycles -> oVmemReq high 4 cycles (EXEC + 3 waits), oUopValid 1 cycle, next oUopAddr = 7.
- WBG with iBgWrAck held low, ACK_TIMEOUT=16 -> oBgWrReq drops after 16 wait cycles, oError=1, oRunning=0, iEnable cannot restart until Reset.
- iRestart pulsed during WAIT_VMEM at PC=12, ack arrives -> next fetch address is 0, not 13.
- GOTO 255 followed by NOP at 255 -> next address 0 (wrap); iEnable dropped during EXEC -> IDLE after EXEC, oRunning falls same edge.
